mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit; consumes the M-stage bundle from the EX/MEM pipeline register and produces the registered W-stage writeback bundle.
- Drives a valid/ready data-memory request channel and accepts a separate response channel.
- Performs byte-lane steering and load sign/zero extension, and selects the writeback result.
- Asserts stallM to freeze the PC, IF/ID, ID/EX and EX/MEM registers while a memory access is outstanding.

---
 rtl/mem_stage_lsu.sv | 152 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues the data-memory request for the M-stage op,
// steers store lanes, extracts/extends load data and registers the W-stage bundle.
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memWriteM,
    input  logic            regWriteM,
    input  logic            luiM,
    input  logic [1:0]      resultSrcM,
    input  logic [4:0]      RdM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] writeDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] extImmM,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stallM,
    output logic            regWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] resultW,
    output logic            misalignW
);

    typedef enum logic {IDLE, WAIT_RSP} state_t;

    state_t          r_state, w_state_nxt;
    logic            w_load, w_store, w_memop, w_misalign;
    logic [1:0]      w_off;
    logic [XLEN-1:0] w_shift, w_load_val, w_result;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_load     = (resultSrcM == 2'b01) && !memWriteM;
    assign w_store    = memWriteM;
    assign w_memop    = w_load || w_store;
    assign w_off      = ALUResultM[1:0];
    assign w_misalign = w_memop &&
                        (((funct3M[1:0] == 2'b01) && w_off[0]) ||
                         ((funct3M[1:0] == 2'b10) && (w_off != 2'b00)));

    assign dmem_we   = w_store;
    assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};

    // Store lane steering: narrow data is replicated so any lane picks it up.
    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = writeDataM;
        if (w_store) begin
            unique case (funct3M[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << w_off;
                    dmem_wdata = {4{writeDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{writeDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = writeDataM;
                end
            endcase
        end
    end

    // Load extraction relies on the M inputs being frozen while waiting for data.
    assign w_shift = dmem_rdata >> {w_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_val = dmem_rdata;
        unique case (funct3M)
            3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        w_result = ALUResultM;
        if (luiM) begin
            w_result = extImmM;
        end else begin
            unique case (resultSrcM)
                2'b00:   w_result = ALUResultM;
                2'b01:   w_result = w_load_val;
                2'b10:   w_result = PCPlus4M;
                default: w_result = extImmM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Responses seen in IDLE are ignored, which also drops stale ones after reset.
    always_comb begin
        w_state_nxt    = r_state;
        dmem_req_valid = 1'b0;
        stallM         = 1'b0;
        unique case (r_state)
            IDLE: begin
                dmem_req_valid = w_memop && !w_misalign;
                if (dmem_req_valid) begin
                    if (w_load) begin
                        stallM = 1'b1;
                        if (dmem_req_ready) w_state_nxt = WAIT_RSP;
                    end else begin
                        stallM = !dmem_req_ready;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) w_state_nxt = IDLE;
                else                stallM      = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWriteW <= 1'b0;
            RdW       <= '0;
            resultW   <= '0;
            misalignW <= 1'b0;
        end else if (stallM) begin
            regWriteW <= 1'b0;
            misalignW <= 1'b0;
        end else begin
            regWriteW <= regWriteM && !w_misalign;
            RdW       <= RdM;
            resultW   <= w_misalign ? '0 : w_result;
            misalignW <= w_misalign;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model of the M->W step.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWriteM, regWriteM, luiM;
    logic [1:0]  resultSrcM;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, writeDataM, PCPlus4M, extImmM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        stallM, regWriteW, misalignW;
    logic [4:0]  RdW;
    logic [31:0] resultW;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0]  exp_rdw;
    logic [31:0] exp_res;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .memWriteM(memWriteM), .regWriteM(regWriteM), .luiM(luiM),
        .resultSrcM(resultSrcM), .RdM(RdM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .writeDataM(writeDataM),
        .PCPlus4M(PCPlus4M), .extImmM(extImmM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .regWriteW(regWriteW), .RdW(RdW),
        .resultW(resultW), .misalignW(misalignW)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble();
        chk("bub_regw", 32'(regWriteW), 32'd0);
        chk("bub_mis", 32'(misalignW), 32'd0);
        chk("bub_rd", 32'(RdW), 32'(exp_rdw));
        chk("bub_res", resultW, exp_res);
    endtask

    task automatic chk_w(input logic rw, input logic [4:0] rd, input logic [31:0] res, input logic mis);
        exp_rdw = rd;
        exp_res = res;
        chk("w_regw", 32'(regWriteW), 32'(rw));
        chk("w_rd", 32'(RdW), 32'(rd));
        chk("w_res", resultW, res);
        chk("w_mis", 32'(misalignW), 32'(mis));
    endtask

    // One M-stage instruction held until it retires; ready/response arrive after given delays.
    task automatic do_op(input logic mw, input logic rw, input logic lui, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4, input logic [31:0] imm,
                         input int rdly, input int sdly, input logic [31:0] rdata);
        logic        is_ld, is_st, mis;
        logic [31:0] b, h, lv, exp_r, exp_wd;
        logic [3:0]  exp_be;
        int          o;
        memWriteM = mw; regWriteM = rw; luiM = lui; resultSrcM = rs; RdM = rd;
        funct3M = f3; ALUResultM = alu; writeDataM = wd; PCPlus4M = pc4; extImmM = imm;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = rdata;

        is_ld = (rs == 2'd1) && !mw;
        is_st = mw;
        o = int'(alu % 4);
        mis = (is_ld || is_st) && (((f3 % 4 == 1) && (alu % 2 != 0)) || ((f3 % 4 == 2) && (o != 0)));
        b = (rdata >> (8 * o)) & 32'hFF;
        h = (rdata >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    lv = (b >= 128) ? b - 32'd256 : b;
            3'd1:    lv = (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    lv = b;
            3'd5:    lv = h;
            default: lv = rdata;
        endcase
        if (lui)          exp_r = imm;
        else if (rs == 0) exp_r = alu;
        else if (rs == 1) exp_r = lv;
        else if (rs == 2) exp_r = pc4;
        else              exp_r = imm;
        case (f3 % 4)
            0:       begin exp_be = 4'(1 << o);            exp_wd = (wd & 32'hFF) * 32'h01010101; end
            1:       begin exp_be = (o >= 2) ? 4'hC : 4'h3; exp_wd = (wd & 32'hFFFF) * 32'h00010001; end
            default: begin exp_be = 4'hF;                   exp_wd = wd; end
        endcase

        if (mis || !(is_ld || is_st)) begin
            #4;
            chk("noreq_valid", 32'(dmem_req_valid), 32'd0);
            chk("noreq_stall", 32'(stallM), 32'd0);
            step();
            chk_w(mis ? 1'b0 : rw, rd, mis ? 32'd0 : exp_r, mis);
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                dmem_req_ready = (i == rdly);
                #4;
                chk("req_valid", 32'(dmem_req_valid), 32'd1);
                chk("req_we", 32'(dmem_we), 32'(is_st));
                chk("req_addr", dmem_addr, alu & 32'hFFFFFFFC);
                chk("req_be", 32'(dmem_be), is_st ? 32'(exp_be) : 32'd0);
                if (is_st) chk("req_wdata", dmem_wdata, exp_wd);
                chk("req_stall", 32'(stallM), (is_ld || i != rdly) ? 32'd1 : 32'd0);
                step();
                if (is_ld || i != rdly) chk_bubble();
            end
            dmem_req_ready = 1'b0;
            if (is_ld) begin
                for (int j = 0; j <= sdly; j++) begin
                    dmem_rsp_valid = (j == sdly);
                    #4;
                    chk("wait_valid", 32'(dmem_req_valid), 32'd0);
                    chk("wait_stall", 32'(stallM), (j != sdly) ? 32'd1 : 32'd0);
                    step();
                    if (j != sdly) chk_bubble();
                end
                dmem_rsp_valid = 1'b0;
            end
            chk_w(rw, rd, exp_r, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        memWriteM = 0; regWriteM = 0; luiM = 0; resultSrcM = 0; RdM = 0; funct3M = 0;
        ALUResultM = 0; writeDataM = 0; PCPlus4M = 0; extImmM = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        exp_rdw = 0; exp_res = 0;
        step(); step();
        chk("rst_regw", 32'(regWriteW), 32'd0);
        chk("rst_rd", 32'(RdW), 32'd0);
        chk("rst_res", resultW, 32'd0);
        chk("rst_mis", 32'(misalignW), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        rst = 1'b0;
        step();

        // Directed cases
        do_op(0, 1, 0, 2'b00, 5'd5, 3'd0, 32'h1234, 0, 32'h44, 32'h55, 0, 0, 0);
        do_op(1, 0, 0, 2'b00, 5'd0, 3'd0, 32'h103, 32'h123456AB, 0, 0, 0, 0, 0);
        do_op(0, 1, 0, 2'b01, 5'd9, 3'd0, 32'h2003, 0, 0, 0, 2, 0, 32'h80FF0000);
        chk("lb_dir", resultW, 32'hFFFFFF80);
        do_op(0, 1, 0, 2'b01, 5'd9, 3'd4, 32'h2003, 0, 0, 0, 2, 0, 32'h80FF0000);
        chk("lbu_dir", resultW, 32'h00000080);
        do_op(0, 1, 0, 2'b01, 5'd3, 3'd1, 32'h2001, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        chk("lh_mis_dir", 32'(misalignW), 32'd1);
        do_op(0, 1, 1, 2'b00, 5'd4, 3'd0, 32'h1111, 0, 0, 32'hABCDE000, 0, 0, 0);
        chk("lui_dir", resultW, 32'hABCDE000);
        do_op(1, 0, 0, 2'b00, 5'd6, 3'd1, 32'h2002, 32'hCAFE1234, 0, 0, 2, 0, 0);
        do_op(0, 1, 0, 2'b01, 5'd8, 3'd5, 32'h2002, 0, 0, 0, 0, 3, 32'h9ABC5678);

        // Reset while waiting on a load: the late response must be dropped.
        memWriteM = 0; regWriteM = 1; luiM = 0; resultSrcM = 2'b01; RdM = 5'd7;
        funct3M = 3'd2; ALUResultM = 32'h2000; dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstw_rd", 32'(RdW), 32'd0);
        chk("rstw_res", resultW, 32'd0);
        step();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h12345678;
        #4;
        chk("stale_stall", 32'(stallM), 32'd1);
        chk("stale_valid", 32'(dmem_req_valid), 32'd1);
        step();
        dmem_rsp_valid = 1'b0;
        chk("stale_regw", 32'(regWriteW), 32'd0);
        chk("stale_rd", 32'(RdW), 32'd0);
        chk("stale_res", resultW, 32'd0);
        exp_rdw = 0; exp_res = 0;
        do_op(0, 0, 0, 2'b00, 5'd0, 3'd0, 32'd0, 0, 0, 0, 0, 0, 0);

        // Random mix of ALU, load and store ops
        for (int k = 0; k < 200; k++) begin
            int          cls;
            logic [31:0] a;
            logic [1:0]  rsel;
            cls  = int'($urandom_range(0, 2));
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            rsel = 2'($urandom_range(0, 2));
            if (rsel == 2'd1) rsel = 2'd3;
            case (cls)
                0: do_op(0, 1'($urandom), 1'($urandom), rsel, 5'($urandom), 3'($urandom), a,
                         $urandom, $urandom, $urandom, 0, 0, $urandom);
                1: do_op(0, 1'($urandom), 0, 2'b01, 5'($urandom), 3'($urandom), a,
                         $urandom, $urandom, $urandom, int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 2)), $urandom);
                default: do_op(1, 1'($urandom), 0, rsel, 5'($urandom), 3'($urandom_range(0, 2)), a,
                               $urandom, $urandom, $urandom, int'($urandom_range(0, 2)), 0, $urandom);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
